// File: rtl/mips_multicycle_core_if.sv
// Shared instruction/data memory port of the multicycle MIPS core.
// The core drives the request side (master); the memory fabric answers (slave).
interface mips_multicycle_core_if;
   localparam int unsigned XLEN = 32;

   logic            mem_req;
   logic            mem_we;
   logic [XLEN-1:0] mem_addr;
   logic [XLEN-1:0] mem_wdata;
   logic [XLEN-1:0] mem_rdata;
   logic            mem_ready;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ready
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ready
   );
endinterface

// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS-32 core: FETCH/DECODE/EXEC/MEM/WB over one handshaked memory port.
// Optional feature macro: MIPS_MC_JUMP_EN enables j, jal and jr (otherwise they execute as NOPs).
module mips_multicycle_core #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] SP_RESET = 32'h0000_0FFC
) (
   input  logic                          clk,
   input  logic                          reset,
   mips_multicycle_core_if.master        mem,
   output logic [31:0]                   ALUResultOut,
   output logic                          instr_retired,
   output logic [2:0]                    state_out
);
   localparam int unsigned XLEN = 32;
   localparam int unsigned NREG = 32;
   localparam int unsigned RIDX = 5;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_BEQ   = 6'd4;
   localparam logic [5:0] OP_BNE   = 6'd5;
   localparam logic [5:0] OP_ADDI  = 6'd8;
   localparam logic [5:0] OP_SLTI  = 6'd10;
   localparam logic [5:0] OP_ANDI  = 6'd12;
   localparam logic [5:0] OP_ORI   = 6'd13;
   localparam logic [5:0] OP_LUI   = 6'd15;
   localparam logic [5:0] OP_LW    = 6'd35;
   localparam logic [5:0] OP_SW    = 6'd43;

   localparam logic [5:0] FN_SLL   = 6'd0;
   localparam logic [5:0] FN_SRL   = 6'd2;
   localparam logic [5:0] FN_ADD   = 6'd32;
   localparam logic [5:0] FN_SUB   = 6'd34;
   localparam logic [5:0] FN_AND   = 6'd36;
   localparam logic [5:0] FN_OR    = 6'd37;
   localparam logic [5:0] FN_NOR   = 6'd39;
   localparam logic [5:0] FN_SLT   = 6'd42;

`ifdef MIPS_MC_JUMP_EN
   localparam logic [5:0] OP_J     = 6'd2;
   localparam logic [5:0] OP_JAL   = 6'd3;
   localparam logic [5:0] FN_JR    = 6'd8;
`endif

   state_t            state, state_nxt;
   logic [XLEN-1:0]   pc, ir, mdr, a, b, alu_out;
   logic [XLEN-1:0]   rf [NREG];

   // Next-state / datapath control, decoded from state and IR
   logic              pc_we, ir_we, mdr_we, ab_we, alu_we, rf_we, retire_c;
   logic              req_c, we_c;
   logic [XLEN-1:0]   pc_nxt, alu_nxt, rf_wdata, addr_c;
   logic [RIDX-1:0]   rf_waddr;

   logic [5:0]        op, funct;
   logic [RIDX-1:0]   rs, rt, rd, shamt;
   logic [15:0]       imm;
   logic [XLEN-1:0]   imm_sext, imm_zext;
   logic [XLEN-1:0]   r_result, i_result;
   logic              r_valid;

   assign op       = ir[31:26];
   assign rs       = ir[25:21];
   assign rt       = ir[20:16];
   assign rd       = ir[15:11];
   assign shamt    = ir[10:6];
   assign funct    = ir[5:0];
   assign imm      = ir[15:0];
   assign imm_sext = {{16{imm[15]}}, imm};
   assign imm_zext = {16'h0000, imm};

   // R-type ALU; r_valid flags the funct codes that write back
   always_comb begin
      r_result = '0;
      r_valid  = 1'b1;
      case (funct)
         FN_ADD:  r_result = a + b;
         FN_SUB:  r_result = a - b;
         FN_AND:  r_result = a & b;
         FN_OR:   r_result = a | b;
         FN_NOR:  r_result = ~(a | b);
         FN_SLT:  r_result = XLEN'($signed(a) < $signed(b));
         FN_SLL:  r_result = b << shamt;
         FN_SRL:  r_result = b >> shamt;
         default: r_valid  = 1'b0;
      endcase
   end

   // Immediate ALU
   always_comb begin
      i_result = '0;
      case (op)
         OP_ADDI: i_result = a + imm_sext;
         OP_SLTI: i_result = XLEN'($signed(a) < $signed(imm_sext));
         OP_ANDI: i_result = a & imm_zext;
         OP_ORI:  i_result = a | imm_zext;
         OP_LUI:  i_result = {imm, 16'h0000};
         default: i_result = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) state <= FETCH;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      pc_we     = 1'b0;
      pc_nxt    = pc;
      ir_we     = 1'b0;
      mdr_we    = 1'b0;
      ab_we     = 1'b0;
      alu_we    = 1'b0;
      alu_nxt   = alu_out;
      rf_we     = 1'b0;
      rf_waddr  = '0;
      rf_wdata  = '0;
      retire_c  = 1'b0;
      req_c     = 1'b0;
      we_c      = 1'b0;
      addr_c    = '0;
      case (state)
         FETCH: begin
            req_c  = 1'b1;
            addr_c = {pc[XLEN-1:2], 2'b00};
            if (mem.mem_ready) begin
               ir_we     = 1'b1;
               pc_we     = 1'b1;
               pc_nxt    = pc + 32'd4;
               state_nxt = DECODE;
            end
         end
         DECODE: begin
            ab_we     = 1'b1;
            alu_we    = 1'b1;
            alu_nxt   = pc + {imm_sext[XLEN-3:0], 2'b00};
            state_nxt = EXEC;
         end
         EXEC: begin
            // Branches, jumps and unknown encodings finish here
            state_nxt = FETCH;
            retire_c  = 1'b1;
            case (op)
               OP_RTYPE: begin
                  if (r_valid) begin
                     alu_we    = 1'b1;
                     alu_nxt   = r_result;
                     state_nxt = WB;
                     retire_c  = 1'b0;
                  end
`ifdef MIPS_MC_JUMP_EN
                  else if (funct == FN_JR) begin
                     pc_we  = 1'b1;
                     pc_nxt = a;
                  end
`endif
               end
               OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: begin
                  alu_we    = 1'b1;
                  alu_nxt   = i_result;
                  state_nxt = WB;
                  retire_c  = 1'b0;
               end
               OP_LW, OP_SW: begin
                  alu_we    = 1'b1;
                  alu_nxt   = a + imm_sext;
                  state_nxt = MEM;
                  retire_c  = 1'b0;
               end
               OP_BEQ: begin
                  if (a == b) begin
                     pc_we  = 1'b1;
                     pc_nxt = alu_out;
                  end
               end
               OP_BNE: begin
                  if (a != b) begin
                     pc_we  = 1'b1;
                     pc_nxt = alu_out;
                  end
               end
`ifdef MIPS_MC_JUMP_EN
               OP_J: begin
                  pc_we  = 1'b1;
                  pc_nxt = {pc[XLEN-1:28], ir[25:0], 2'b00};
               end
               OP_JAL: begin
                  pc_we    = 1'b1;
                  pc_nxt   = {pc[XLEN-1:28], ir[25:0], 2'b00};
                  rf_we    = 1'b1;
                  rf_waddr = RIDX'(31);
                  rf_wdata = pc;
               end
`endif
               default: ;
            endcase
         end
         MEM: begin
            req_c  = 1'b1;
            addr_c = {alu_out[XLEN-1:2], 2'b00};
            we_c   = (op == OP_SW);
            if (mem.mem_ready) begin
               if (op == OP_SW) begin
                  state_nxt = FETCH;
                  retire_c  = 1'b1;
               end else begin
                  mdr_we    = 1'b1;
                  state_nxt = WB;
               end
            end
         end
         WB: begin
            rf_we     = 1'b1;
            rf_waddr  = (op == OP_RTYPE) ? rd : rt;
            rf_wdata  = (op == OP_LW) ? mdr : alu_out;
            state_nxt = FETCH;
            retire_c  = 1'b1;
         end
         default: state_nxt = FETCH;
      endcase
   end

   // Datapath registers and register file; reset overrides any in-flight update
   always_ff @(posedge clk) begin
      if (!reset) begin
         pc            <= RESET_PC;
         ir            <= '0;
         mdr           <= '0;
         a             <= '0;
         b             <= '0;
         alu_out       <= '0;
         instr_retired <= 1'b0;
         for (int i = 0; i < NREG; i++) begin
            rf[i] <= (i == 29) ? SP_RESET : '0;
         end
      end else begin
         if (pc_we)  pc      <= pc_nxt;
         if (ir_we)  ir      <= mem.mem_rdata;
         if (mdr_we) mdr     <= mem.mem_rdata;
         if (alu_we) alu_out <= alu_nxt;
         if (ab_we) begin
            a <= rf[rs];
            b <= rf[rt];
         end
         if (rf_we && (rf_waddr != '0)) rf[rf_waddr] <= rf_wdata;
         instr_retired <= retire_c;
      end
   end

   // Memory request is a pure state decode, held low throughout reset
   assign mem.mem_req   = req_c & reset;
   assign mem.mem_we    = we_c & reset;
   assign mem.mem_addr  = addr_c;
   assign mem.mem_wdata = b;

   assign ALUResultOut  = alu_out;
   assign state_out     = state;
endmodule
